// File: rtl/wb_pkg.sv
// Writeback arbiter shared types and helpers.
// Register address width, entry bundle and round-robin pointer step.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WB_DATA_W  = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0]  wdata;
  } wb_entry_t;

  function automatic logic [2:0] rr_next(
    input logic [2:0]  last,
    input int unsigned n
  );
    if (int'(last) + 1 >= int'(n)) return 3'd0;
    return last + 3'd1;
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result buffer: circular FIFO with push/pop/flush.
// Flush wins over push and pop in the same cycle.
module wb_src_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DW-1:0]         wdata_i,
  output logic [REG_ADDR_W-1:0] head_addr_o,
  output logic [DW-1:0]         head_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  nempty_d_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] addr_q [DEPTH];
  logic [DW-1:0]         data_q [DEPTH];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + AW'(1);
      if (pop_i)  rd_d = rd_q + AW'(1);
      if (push_i && !pop_i)
        cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i)
        cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      addr_q[wr_q] <= waddr_i;
      data_q[wr_q] <= wdata_i;
    end
  end

  assign head_addr_o = addr_q[rd_q];
  assign head_data_o = data_q[rd_q];
  assign full_o      = (cnt_q == CW'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign nempty_d_o  = (cnt_d != '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback stage: buffers per-source results and arbitrates them
// round-robin onto conflict-free registered regfile write ports.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NR_SRC        = 4,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter bit          ZERO_REG_ZERO = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NR_SRC-1:0]                 src_valid_i,
  output logic [NR_SRC-1:0]                 src_ready_o,
  input  logic [NR_SRC*REG_ADDR_W-1:0]      src_waddr_i,
  input  logic [NR_SRC*DATA_WIDTH-1:0]      src_wdata_i,
  output logic [NR_WB_PORTS*REG_ADDR_W-1:0] waddr_o,
  output logic [NR_WB_PORTS*DATA_WIDTH-1:0] wdata_o,
  output logic [NR_WB_PORTS-1:0]            we_o,
  output logic                              busy_o
);

  logic [NR_SRC-1:0] full, empty, nempty_d, push, pop, gnt;
  logic [REG_ADDR_W-1:0] head_a [NR_SRC];
  logic [DATA_WIDTH-1:0] head_d [NR_SRC];

  assign src_ready_o = ~full;
  assign push = flush_i ? '0 : (src_valid_i & ~full);
  assign pop  = flush_i ? '0 : gnt;

  for (genvar s = 0; s < NR_SRC; s++) begin : g_fifo
    wb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DATA_WIDTH)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .push_i      (push[s]),
      .pop_i       (pop[s]),
      .waddr_i     (src_waddr_i[s*REG_ADDR_W +: REG_ADDR_W]),
      .wdata_i     (src_wdata_i[s*DATA_WIDTH +: DATA_WIDTH]),
      .head_addr_o (head_a[s]),
      .head_data_o (head_d[s]),
      .full_o      (full[s]),
      .empty_o     (empty[s]),
      .nempty_d_o  (nempty_d[s])
    );
  end

  logic [2:0] rr_q, rr_d;
  logic [NR_WB_PORTS-1:0] pv_d, pwe_d;
  logic [REG_ADDR_W-1:0] pa_d [NR_WB_PORTS];
  logic [DATA_WIDTH-1:0] pd_d [NR_WB_PORTS];

  // A head whose address is already granted this cycle waits; scan goes on.
  always_comb begin
    int n;
    int s;
    logic hit;
    gnt   = '0;
    pv_d  = '0;
    pwe_d = '0;
    rr_d  = rr_q;
    n     = 0;
    s     = 0;
    hit   = 1'b0;
    for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
      pa_d[k] = '0;
      pd_d[k] = '0;
    end
    for (int i = 0; i < int'(NR_SRC); i++) begin
      s   = (int'(rr_q) + i) % int'(NR_SRC);
      hit = 1'b0;
      for (int k = 0; k < int'(NR_WB_PORTS); k++)
        if (pv_d[k] && pa_d[k] == head_a[s]) hit = 1'b1;
      if (!empty[s] && n < int'(NR_WB_PORTS) && !hit) begin
        gnt[s]   = 1'b1;
        pv_d[n]  = 1'b1;
        pa_d[n]  = head_a[s];
        pd_d[n]  = head_d[s];
        pwe_d[n] = !(ZERO_REG_ZERO && head_a[s] == '0);
        rr_d     = rr_next(3'(s), NR_SRC);
        n++;
      end
    end
  end

  logic [NR_WB_PORTS-1:0] we_q;
  logic [REG_ADDR_W-1:0]  waddr_q [NR_WB_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_q [NR_WB_PORTS];
  logic                   busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q   <= '0;
      we_q   <= '0;
      busy_q <= 1'b0;
      for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
      end
    end else if (flush_i) begin
      rr_q   <= '0;
      we_q   <= '0;
      busy_q <= 1'b0;
      for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
        waddr_q[k] <= '0;
        wdata_q[k] <= '0;
      end
    end else begin
      rr_q   <= rr_d;
      we_q   <= pwe_d;
      busy_q <= (|nempty_d) | (|pwe_d);
      for (int k = 0; k < int'(NR_WB_PORTS); k++) begin
        if (pv_d[k]) begin
          waddr_q[k] <= pa_d[k];
          wdata_q[k] <= pd_d[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NR_WB_PORTS; k++) begin : g_out
    assign waddr_o[k*REG_ADDR_W +: REG_ADDR_W] = waddr_q[k];
    assign wdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_q[k];
  end

  assign we_o   = we_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: latency, round-robin,
// address conflicts, backpressure, x0 drop, flush and reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready, src_ready_z;
  logic [19:0] src_waddr;
  logic [127:0] src_wdata;
  logic [9:0]  waddr, waddr_z;
  logic [63:0] wdata, wdata_z;
  logic [1:0]  we, we_z;
  logic        busy, busy_z;

  int checks = 0;
  int errors = 0;

  logic [4:0]  qa [4][8];
  logic [31:0] qd [4][8];
  int          qh [4];
  int          qt [4];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NR_SRC(4), .NR_WB_PORTS(2), .DATA_WIDTH(32),
    .FIFO_DEPTH(2), .ZERO_REG_ZERO(1'b0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_waddr_i(src_waddr), .src_wdata_i(src_wdata),
    .waddr_o(waddr), .wdata_o(wdata), .we_o(we), .busy_o(busy)
  );

  regfile_wb_arbiter #(
    .NR_SRC(4), .NR_WB_PORTS(2), .DATA_WIDTH(32),
    .FIFO_DEPTH(2), .ZERO_REG_ZERO(1'b1)
  ) dut_z (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .src_valid_i(src_valid), .src_ready_o(src_ready_z),
    .src_waddr_i(src_waddr), .src_wdata_i(src_wdata),
    .waddr_o(waddr_z), .wdata_o(wdata_z), .we_o(we_z), .busy_o(busy_z)
  );

  for (genvar s = 0; s < 4; s++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (!rst_n || flush)
      (src_valid[s] && !src_ready[s]) |=>
      (src_valid[s] && $stable(src_waddr[s*5 +: 5])
                    && $stable(src_wdata[s*32 +: 32])))
      else $error("source %0d dropped or changed an unaccepted result", s);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_port(input string tag, input int k,
                          input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_a"}, 64'(waddr[k*5 +: 5]), 64'(a));
    chk({tag, "_d"}, 64'(wdata[k*32 +: 32]), 64'(d));
  endtask

  task automatic refresh();
    for (int s = 0; s < 4; s++) begin
      if (qh[s] < qt[s]) begin
        src_valid[s]         = 1'b1;
        src_waddr[s*5 +: 5]  = qa[s][qh[s]];
        src_wdata[s*32 +: 32] = qd[s][qh[s]];
      end else begin
        src_valid[s] = 1'b0;
      end
    end
  endtask

  task automatic clr();
    for (int s = 0; s < 4; s++) begin
      qh[s] = 0;
      qt[s] = 0;
    end
    refresh();
  endtask

  task automatic put(input int s, input logic [4:0] a, input logic [31:0] d);
    qa[s][qt[s]] = a;
    qd[s][qt[s]] = d;
    qt[s]++;
    refresh();
  endtask

  task automatic step();
    logic [3:0] acc;
    acc = (flush || !rst_n) ? 4'b0 : (src_valid & src_ready);
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++)
      if (acc[s]) qh[s]++;
    refresh();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    src_valid = '0;
    src_waddr = '0;
    src_wdata = '0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_waddr", 64'(waddr), 64'(0));
    chk("rst_wdata", wdata, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(src_ready), 64'(4'hF));

    // single source latency
    put(0, 5'd5, 32'hDEADBEEF);
    step();
    chk("t1_c2_we", 64'(we), 64'(0));
    chk("t1_c2_busy", 64'(busy), 64'(1));
    step();
    chk("t1_c3_we", 64'(we), 64'(2'b01));
    chk_port("t1_p0", 0, 5'd5, 32'hDEADBEEF);
    step();
    chk("t1_c4_busy", 64'(busy), 64'(0));
    chk("t1_c4_we", 64'(we), 64'(0));

    // four sources, round-robin from 0
    do_flush();
    chk("t2_rr0", 64'(dut.rr_q), 64'(0));
    for (int s = 0; s < 4; s++) put(s, 5'(s + 1), 32'hA0 + 32'(s));
    step();
    step();
    chk("t2_a_we", 64'(we), 64'(2'b11));
    chk_port("t2_a_p0", 0, 5'd1, 32'hA0);
    chk_port("t2_a_p1", 1, 5'd2, 32'hA1);
    step();
    chk("t2_b_we", 64'(we), 64'(2'b11));
    chk_port("t2_b_p0", 0, 5'd3, 32'hA2);
    chk_port("t2_b_p1", 1, 5'd4, 32'hA3);
    chk("t2_rr", 64'(dut.rr_q), 64'(0));
    step();
    chk("t2_idle_we", 64'(we), 64'(0));

    // address conflict on x7
    put(0, 5'd7, 32'h11);
    put(1, 5'd7, 32'h22);
    put(2, 5'd9, 32'h33);
    step();
    step();
    chk("t3_a_we", 64'(we), 64'(2'b11));
    chk_port("t3_a_p0", 0, 5'd7, 32'h11);
    chk_port("t3_a_p1", 1, 5'd9, 32'h33);
    step();
    chk("t3_b_we", 64'(we), 64'(2'b01));
    chk_port("t3_b_p0", 0, 5'd7, 32'h22);
    chk("t3_rr", 64'(dut.rr_q), 64'(2));
    step();
    chk("t3_idle_we", 64'(we), 64'(0));

    // backpressure on src0 while others hold the ports
    do_flush();
    clr();
    for (int s = 1; s < 4; s++) begin
      put(s, 5'(18 + 2 * s), 32'h1000 + 32'(18 + 2 * s));
      put(s, 5'(19 + 2 * s), 32'h1000 + 32'(19 + 2 * s));
    end
    step();
    step();
    chk("t4_e2_we", 64'(we), 64'(2'b11));
    chk_port("t4_e2_p0", 0, 5'd20, 32'h1014);
    chk_port("t4_e2_p1", 1, 5'd22, 32'h1016);
    for (int i = 0; i < 3; i++) put(0, 5'(10 + i), 32'h1000 + 32'(10 + i));
    step();
    chk("t4_e3_rdy0", 64'(src_ready[0]), 64'(1));
    chk_port("t4_e3_p0", 0, 5'd24, 32'h1018);
    chk_port("t4_e3_p1", 1, 5'd21, 32'h1015);
    step();
    chk("t4_e4_rdy0", 64'(src_ready[0]), 64'(0));
    chk_port("t4_e4_p0", 0, 5'd23, 32'h1017);
    chk_port("t4_e4_p1", 1, 5'd25, 32'h1019);
    step();
    chk("t4_e5_rdy0", 64'(src_ready[0]), 64'(1));
    chk("t4_e5_we", 64'(we), 64'(2'b01));
    chk_port("t4_e5_p0", 0, 5'd10, 32'h100A);
    step();
    chk("t4_e6_we", 64'(we), 64'(2'b01));
    chk_port("t4_e6_p0", 0, 5'd11, 32'h100B);
    step();
    chk("t4_e7_we", 64'(we), 64'(2'b01));
    chk_port("t4_e7_p0", 0, 5'd12, 32'h100C);
    step();
    chk("t4_e8_we", 64'(we), 64'(0));
    chk("t4_e8_busy", 64'(busy), 64'(0));

    // x0 writes: dropped only when ZERO_REG_ZERO is set
    do_flush();
    clr();
    put(1, 5'd0, 32'h55);
    step();
    chk("t5_e1_busyz", 64'(busy_z), 64'(1));
    step();
    chk("t5_e2_wez", 64'(we_z), 64'(0));
    chk("t5_e2_busyz", 64'(busy_z), 64'(0));
    chk("t5_e2_we", 64'(we), 64'(2'b01));
    chk_port("t5_e2_p0", 0, 5'd0, 32'h55);
    step();
    chk("t5_e3_wez", 64'(we_z), 64'(0));
    chk("t5_e3_busy", 64'(busy), 64'(0));

    // flush with five entries buffered
    do_flush();
    clr();
    for (int s = 0; s < 4; s++) put(s, 5'(2 * s + 1), 32'hB0 + 32'(s));
    for (int s = 0; s < 3; s++) put(s, 5'(2 * s + 2), 32'hC0 + 32'(s));
    step();
    step();
    chk("t6_e2_we", 64'(we), 64'(2'b11));
    chk("t6_e2_rdy", 64'(src_ready), 64'(4'b1011));
    do_flush();
    chk("t6_fl_we", 64'(we), 64'(0));
    chk("t6_fl_waddr", 64'(waddr), 64'(0));
    chk("t6_fl_wdata", wdata, 64'(0));
    chk("t6_fl_busy", 64'(busy), 64'(0));
    chk("t6_fl_rdy", 64'(src_ready), 64'(4'hF));
    step();
    chk("t6_post_we", 64'(we), 64'(0));

    // asynchronous reset between edges
    clr();
    for (int s = 0; s < 4; s++) put(s, 5'(2 * s + 1), 32'hB0 + 32'(s));
    for (int s = 0; s < 3; s++) put(s, 5'(2 * s + 2), 32'hC0 + 32'(s));
    step();
    step();
    chk("t7_e2_we", 64'(we), 64'(2'b11));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_we", 64'(we), 64'(0));
    chk("t7_rst_waddr", 64'(waddr), 64'(0));
    chk("t7_rst_wdata", wdata, 64'(0));
    chk("t7_rst_busy", 64'(busy), 64'(0));
    #2;
    rst_n = 1'b1;
    step();
    chk("t7_post_we", 64'(we), 64'(0));
    chk("t7_post_rdy", 64'(src_ready), 64'(4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback stage directly upstream of the integer register file.
- Collects results from NR_SRC functional units (ALU, branch, LSU, MUL/CSR) over valid/ready handshakes and buffers each in a small per-source FIFO.
- Each cycle it arbitrates round-robin onto NR_WB_PORTS registered regfile write ports (waddr/wdata/we), guaranteeing no two ports write the same register in one cycle.

Parameters:
- NR_SRC, 4, number of result producers (2..8).
- NR_WB_PORTS, 2, regfile write ports; must equal the regfile's commit-port count (1..NR_SRC).
- DATA_WIDTH, 32, result width.
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2).
- ZERO_REG_ZERO, 0, when 1, writes to x0 are consumed and dropped.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all FIFOs and output regs.
- src_valid_i  in  NR_SRC  result valid per source.
- src_ready_o  out  NR_SRC  source FIFO can accept.
- src_waddr_i  in  NR_SRC*5  destination register per source.
- src_wdata_i  in  NR_SRC*DATA_WIDTH  result data per source.
- waddr_o  out  NR_WB_PORTS*5  regfile write address.
- wdata_o  out  NR_WB_PORTS*DATA_WIDTH  regfile write data.
- we_o  out  NR_WB_PORTS  regfile write enable.
- busy_o  out  1  any FIFO non-empty or any we_o high.

Behaviour:
- Reset (async) and flush (sync): all FIFOs empty, rr_ptr=0, we_o=0, waddr_o=0, wdata_o=0, busy_o=0, src_ready_o all 1 after reset release. flush_i has priority over push/pop in its cycle; inputs presented during flush are not accepted.
- Handshake: src_ready_o[s] = (count[s] < FIFO_DEPTH), a pure function of state, not of valid. Push when valid&ready. Push and pop of the same FIFO in one cycle are allowed; count unchanged. When full, ready stays 0 in a cycle with a pop; it reasserts the next cycle.
- Sources must hold valid/addr/data stable until accepted. The bench checks this with an assertion.
- Arbitration (combinational, on FIFO heads):
  - Scan sources in order rr_ptr, rr_ptr+1, ... mod NR_SRC.
  - Grant each non-empty head until NR_WB_PORTS grants are issued.
  - Skip a head whose waddr equals a waddr already granted this cycle. It waits; the scan continues past it.
  - Grant k in scan order drives port k.
- rr_ptr update: next = (index of last granted source + 1) mod NR_SRC. It is unchanged if nothing is granted.
- Output regs: on the next clock, port k gets we_o=1 with the granted head's addr/data. Unused ports get we_o=0, and their addr/data hold previous values. Granted heads pop the same edge.
- ZERO_REG_ZERO=1: a head with waddr==0 is still granted and popped, but its port's we_o is forced 0.
- Latency: accepted at edge N, granted in cycle N+1 (earliest), we_o high during cycle N+2. Throughput is up to NR_WB_PORTS writes/cycle.
- Ordering: per-source FIFO order is preserved. There is no ordering between sources; the scoreboard handles WAW.
- Starvation-free: any non-empty head is granted within ceil(NR_SRC/NR_WB_PORTS)+1 cycles, except while address-conflict skips persist.
- busy_o is registered and reflects post-edge state.

Decomposition:
- Shared package (wb_pkg):
  - REG_ADDR_W=5.
  - wb_entry_t {logic [4:0] waddr; logic [DATA_WIDTH-1:0] wdata} (parameterised via DATA_WIDTH localparam).
  - Function rr_next(last, n).
- Sub-module wb_src_fifo (one per source, generated): FIFO_DEPTH-entry circular buffer with count, push/pop/flush, head and full/empty outputs.
- Arbiter and output registers stay in the top level.

Test Plan:
- Single source: src0 pushes addr=5 data=0xDEADBEEF at cycle 1 -> we_o[0]=1, waddr_o[0]=5, wdata_o[0]=0xDEADBEEF in cycle 3; we_o[1]=0; busy_o falls at cycle 4.
- Four sources push simultaneously with addrs 1,2,3,4, rr_ptr=0:
  - Cycle N+2: ports = src0, src1.
  - Cycle N+3: ports = src2, src3.
  - rr_ptr ends at 0.
- Address conflict: src0 and src1 both target x7 (data 0x11, 0x22), src2 targets x9 ->
  - First cycle writes x7=0x11 (port0) and x9 (port1).
  - Next cycle writes x7=0x22 (port0).
- Backpressure: src0 pushes 3 back-to-back, other sources keep ports busy -> src0_ready=0 after 2 accepts; third accepted only after the first pop; all three written in order.
- ZERO_REG_ZERO=1: src1 pushes addr=0 data=0x55 -> entry popped, we_o stays 0 on all ports, busy_o returns 0.
- Flush/reset mid-operation:
  - With 5 entries buffered, assert flush_i one cycle -> no further we_o, all ready=1 next cycle.
  - Repeat with rst_ni low asynchronously between edges -> outputs 0 immediately.
